// File: rtl/sevenseg_reader.sv
// Readback monitor for a multiplexed active-low 7-segment bus: recovers per-digit values
// after STABLE_CYCLES identical samples. Define SEVENSEG_READER_ERR_EN to commit invalid patterns.
module sevenseg_reader #(
  parameter int unsigned NUM_DIGITS    = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   anode_in,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic [NUM_DIGITS-1:0]   pattern_err,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [7:0]              out_idx,
  output logic [3:0]              out_val,
  output logic                    out_err,
  output logic                    ovf
);

  localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

  logic [6:0]              r_seg;
  logic [NUM_DIGITS-1:0]   r_anode;
  logic [7:0]              r_cnt;
  logic [7:0]              r_cand_idx;
  logic [6:0]              r_cand_seg;
  logic [4*NUM_DIGITS-1:0] r_digits;
  logic [NUM_DIGITS-1:0]   r_dvalid;
  logic [NUM_DIGITS-1:0]   r_perr;
  logic                    r_out_valid;
  logic [7:0]              r_out_idx;
  logic [3:0]              r_out_val;
  logic                    r_out_err;
  logic                    r_ovf;

  logic [7:0] w_idx;
  logic [7:0] w_nlow;
  logic       w_active;
  logic [3:0] w_val;
  logic       w_invalid;
  logic       w_inv_eff;
  logic       w_same;
  logic [7:0] w_cnt_nxt;
  logic       w_reach;
  logic       w_commit;
  logic [3:0] w_old_val;
  logic       w_old_dv;
  logic       w_old_err;
  logic       w_change;

  always_comb begin
    w_idx  = '0;
    w_nlow = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (!r_anode[i]) begin
        w_idx  = 8'(i);
        w_nlow = w_nlow + 8'd1;
      end
    end
    w_active = (w_nlow == 8'd1);
  end

  always_comb begin
    w_val     = '0;
    w_invalid = 1'b0;
    case (r_seg)
      7'b1000000: w_val = 4'd0;
      7'b1111001: w_val = 4'd1;
      7'b0100100: w_val = 4'd2;
      7'b0110000: w_val = 4'd3;
      7'b0011001: w_val = 4'd4;
      7'b0010010: w_val = 4'd5;
      7'b0000010: w_val = 4'd6;
      7'b1111000: w_val = 4'd7;
      7'b0000000: w_val = 4'd8;
      7'b0010000: w_val = 4'd9;
      default:    w_invalid = 1'b1;
    endcase
  end

  // A nonzero count implies the previous sample was an active digit.
  assign w_same = (r_cnt != '0) && (r_cand_idx == w_idx) && (r_cand_seg == r_seg);

  always_comb begin
    w_cnt_nxt = '0;
    if (w_active) begin
      if (!w_same)              w_cnt_nxt = 8'd1;
      else if (r_cnt == STABLE) w_cnt_nxt = STABLE;
      else                      w_cnt_nxt = r_cnt + 8'd1;
    end
  end

  assign w_reach = w_active && (w_cnt_nxt == STABLE) && !(w_same && (r_cnt == STABLE));

`ifdef SEVENSEG_READER_ERR_EN
  assign w_commit  = w_reach;
  assign w_inv_eff = w_invalid;
`else
  assign w_commit  = w_reach && !w_invalid;
  assign w_inv_eff = 1'b0;
`endif

  always_comb begin
    w_old_val = '0;
    w_old_dv  = 1'b0;
    w_old_err = 1'b0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (w_idx == 8'(i)) begin
        w_old_val = r_digits[4*i +: 4];
        w_old_dv  = r_dvalid[i];
        w_old_err = r_perr[i];
      end
    end
  end

  assign w_change = w_commit && (!w_old_dv || (w_old_val != w_val) || (w_old_err != w_inv_eff));

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_seg       <= '0;
      r_anode     <= '0;
      r_cnt       <= '0;
      r_cand_idx  <= '0;
      r_cand_seg  <= '0;
      r_digits    <= '0;
      r_dvalid    <= '0;
      r_perr      <= '0;
      r_out_valid <= 1'b0;
      r_out_idx   <= '0;
      r_out_val   <= '0;
      r_out_err   <= 1'b0;
      r_ovf       <= 1'b0;
    end else begin
      r_seg      <= seg_in;
      r_anode    <= anode_in;
      r_cnt      <= w_cnt_nxt;
      r_cand_idx <= w_idx;
      r_cand_seg <= r_seg;
      if (w_commit) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (w_idx == 8'(i)) begin
            r_digits[4*i +: 4] <= w_val;
            r_dvalid[i]        <= 1'b1;
            r_perr[i]          <= w_inv_eff;
          end
        end
      end
      // Slot reloads in the same cycle it is accepted, so a busy consumer never sees a gap.
      if (w_change && (!r_out_valid || out_ready)) begin
        r_out_valid <= 1'b1;
        r_out_idx   <= w_idx;
        r_out_val   <= w_val;
        r_out_err   <= w_inv_eff;
      end else begin
        if (w_change)                  r_ovf       <= 1'b1;
        if (r_out_valid && out_ready)  r_out_valid <= 1'b0;
      end
    end
  end

  assign digits      = r_digits;
  assign digit_valid = r_dvalid;
  assign pattern_err = r_perr;
  assign out_valid   = r_out_valid;
  assign out_idx     = r_out_idx;
  assign out_val     = r_out_val;
  assign out_err     = r_out_err;
  assign ovf         = r_ovf;

endmodule
